// File: rtl/conv_window_assembler.sv
// 3x3 window builder on two cascaded line-delay shift registers.
// Build option: STRIDE2_EN adds cfg_stride2 (even row/col windows only).

`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

module conv_window_assembler #(
   parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
   localparam int DW = 2 * FEATURE_WIDTH
) (
   input  logic            system_clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [9:0]      cfg_row_size,
   input  logic [9:0]      cfg_img_rows,
`ifdef STRIDE2_EN
   input  logic            cfg_stride2,
`endif
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic            sr_wr_en,
   output logic [DW-1:0]   sr0_wr_data,
   output logic [DW-1:0]   sr1_wr_data,
   input  logic [DW-1:0]   sr0_tap,
   input  logic [DW-1:0]   sr1_tap,
   output logic [9:0]      sr_shift_size,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [9*DW-1:0] out_window,
   output logic [9:0]      out_row,
   output logic [9:0]      out_col,
   output logic            frame_done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t          state_q;
   logic [9:0]      row_size_q;
   logic [9:0]      img_rows_q;
   logic [9:0]      cnt_row_q;
   logic [9:0]      cnt_col_q;
   logic            frame_done_q;

   logic            p1_v_q;
   logic [DW-1:0]   p1_data_q;
   logic [9:0]      p1_row_q;
   logic [9:0]      p1_col_q;

   logic [9*DW-1:0] win_q;
   logic [9*DW-1:0] win_d;
   logic            out_valid_q;
   logic [9:0]      out_row_q;
   logic [9:0]      out_col_q;

   logic            stall;
   logic            xfer;
   logic            last_px;
   logic            stride_ok;
   logic            win_ok;

`ifdef STRIDE2_EN
   logic            stride2_q;
   assign stride_ok = ~stride2_q | (~p1_row_q[0] & ~p1_col_q[0]);
`else
   assign stride_ok = 1'b1;
`endif

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = (state_q == RUN) & ~stall;
   assign xfer     = in_valid & in_ready;
   assign last_px  = (cnt_row_q == img_rows_q - 10'd1) &
                     (cnt_col_q == row_size_q - 10'd1);
   assign win_ok   = p1_v_q & (p1_row_q >= 10'd2) &
                     (p1_col_q >= 10'd2) & stride_ok;

   // Data only carried alongside the strobe so idle outputs stay 0.
   assign sr_wr_en      = xfer;
   assign sr0_wr_data   = xfer ? in_data : '0;
   assign sr1_wr_data   = xfer ? sr0_tap : '0;
   assign sr_shift_size = row_size_q;
   assign out_valid     = out_valid_q;
   assign out_window    = win_q;
   assign out_row       = out_row_q;
   assign out_col       = out_col_q;
   assign frame_done    = frame_done_q;

   // Window shifts left; new right column is oldest row on top.
   always_comb begin
      win_d = win_q;
      win_d[0*DW +: DW] = win_q[1*DW +: DW];
      win_d[1*DW +: DW] = win_q[2*DW +: DW];
      win_d[2*DW +: DW] = sr1_tap;
      win_d[3*DW +: DW] = win_q[4*DW +: DW];
      win_d[4*DW +: DW] = win_q[5*DW +: DW];
      win_d[5*DW +: DW] = sr0_tap;
      win_d[6*DW +: DW] = win_q[7*DW +: DW];
      win_d[7*DW +: DW] = win_q[8*DW +: DW];
      win_d[8*DW +: DW] = p1_data_q;
   end

   // Frame control: cfg latch, raster position counters, done pulse.
   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         row_size_q   <= '0;
         img_rows_q   <= '0;
         cnt_row_q    <= '0;
         cnt_col_q    <= '0;
         frame_done_q <= 1'b0;
`ifdef STRIDE2_EN
         stride2_q    <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= RUN;
                  row_size_q <= cfg_row_size;
                  img_rows_q <= cfg_img_rows;
                  cnt_row_q  <= '0;
                  cnt_col_q  <= '0;
`ifdef STRIDE2_EN
                  stride2_q  <= cfg_stride2;
`endif
               end
            end
            RUN: begin
               if (xfer) begin
                  if (last_px) state_q <= DRAIN;
                  if (cnt_col_q == row_size_q - 10'd1) begin
                     cnt_col_q <= '0;
                     if (cnt_row_q != img_rows_q - 10'd1)
                        cnt_row_q <= cnt_row_q + 10'd1;
                  end else begin
                     cnt_col_q <= cnt_col_q + 10'd1;
                  end
               end
            end
            DRAIN: begin
               if (!p1_v_q && !out_valid_q) begin
                  state_q      <= DONE;
                  frame_done_q <= 1'b1;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Two-stage pixel/window pipeline, frozen while output stalls.
   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_v_q      <= 1'b0;
         p1_data_q   <= '0;
         p1_row_q    <= '0;
         p1_col_q    <= '0;
         win_q       <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
      end else if (!stall) begin
         p1_v_q <= xfer;
         if (xfer) begin
            p1_data_q <= in_data;
            p1_row_q  <= cnt_row_q;
            p1_col_q  <= cnt_col_q;
         end
         out_valid_q <= win_ok;
         if (p1_v_q) begin
            win_q     <= win_d;
            out_row_q <= p1_row_q - 10'd2;
            out_col_q <= p1_col_q - 10'd2;
         end
      end
   end

endmodule
